// File: rtl/vlg_design.sv
// Registered binary-to-Gray converter: one word per enabled clock, result and
// valid strobe presented one clock later.
module vlg_design #(
    parameter int unsigned MSB = 7
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [MSB:0] i_data,
    output logic         o_vld,
    output logic [MSB:0] o_gray
);

    logic [MSB:0] gray_next;

    // Logical shift zero-fills the top bit, so g[MSB] = b[MSB] falls out naturally.
    always_comb begin
        gray_next = i_data ^ (i_data >> 1);
    end

    // o_gray is only loaded on enabled edges; consumers qualify it with o_vld.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld  <= 1'b0;
            o_gray <= '0;
        end else begin
            o_vld <= i_en;
            if (i_en) begin
                o_gray <= gray_next;
            end
        end
    end

endmodule

// File: tb/tb_vlg_design.sv
// Self-checking bench for vlg_design: directed tables, sweeps, reset cases and
// a randomized run scored against a cycle-level reference model.
module tb_vlg_design;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       vld;
    logic [7:0] gray;
    logic       en_s;
    logic [3:0] data_s;
    logic       vld_s;
    logic [3:0] gray_s;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs must show after the last edge.
    logic       m_vld;
    logic [7:0] m_gray;

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       exp_vld;
        logic [7:0] exp_gray;
    } vec_t;

    vec_t vecs[11];

    vlg_design #(.MSB(7)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_en   (en),
        .i_data (data),
        .o_vld  (vld),
        .o_gray (gray)
    );

    vlg_design #(.MSB(3)) dut_s (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_en   (en_s),
        .i_data (data_s),
        .o_vld  (vld_s),
        .o_gray (gray_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, take the rising edge, sample 1ns later and
    // advance the model.
    task automatic cyc(input logic e, input logic [7:0] d);
        en   = e;
        data = d;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_vld  = 1'b0;
            m_gray = '0;
        end else begin
            m_vld = e;
            if (e) m_gray = to_gray(d);
        end
    endtask

    task automatic chk_model(input string name);
        check({name, "_vld"}, {31'd0, vld}, {31'd0, m_vld});
        check({name, "_gray"}, {24'd0, gray}, {24'd0, m_gray});
    endtask

    initial begin
        int unsigned vld_count;
        logic [7:0]  prev;
        logic [3:0]  exp_s[16];
        logic        e;

        rst_n  = 1'b0;
        en     = 1'b0;
        data   = '0;
        en_s   = 1'b0;
        data_s = '0;
        m_vld  = 1'b0;
        m_gray = '0;

        // Reset held with enable toggling.
        for (int i = 0; i < 100; i++) begin
            cyc(i[0], 8'($urandom));
            check("rst_hold_vld", {31'd0, vld}, 32'd0);
            check("rst_hold_gray", {24'd0, gray}, 32'd0);
        end
        rst_n = 1'b1;

        // Asynchronous assertion between edges clears outputs immediately.
        cyc(1'b1, 8'd255);
        chk_model("pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_vld", {31'd0, vld}, 32'd0);
        check("async_gray", {24'd0, gray}, 32'd0);
        m_vld  = 1'b0;
        m_gray = '0;
        cyc(1'b0, 8'd0);
        rst_n = 1'b1;

        // Exhaustive sweep, continuing into 0 to cover the wrap.
        vld_count = 0;
        prev      = '0;
        for (int i = 0; i < 257; i++) begin
            cyc(1'b1, 8'(i));
            chk_model("sweep");
            if (vld) vld_count++;
            if (i > 0) check("sweep_1bit", $countones(gray ^ prev), 32'd1);
            prev = gray;
        end
        cyc(1'b0, 8'd0);
        chk_model("sweep_end");
        check("sweep_vld_count", vld_count, 32'd257);

        // Directed values and the enable-gap pattern.
        vecs[0]  = '{1'b1, 8'd0,   1'b1, 8'b0000_0000};
        vecs[1]  = '{1'b1, 8'd1,   1'b1, 8'b0000_0001};
        vecs[2]  = '{1'b1, 8'd2,   1'b1, 8'b0000_0011};
        vecs[3]  = '{1'b1, 8'd3,   1'b1, 8'b0000_0010};
        vecs[4]  = '{1'b1, 8'd127, 1'b1, 8'b0100_0000};
        vecs[5]  = '{1'b1, 8'd128, 1'b1, 8'b1100_0000};
        vecs[6]  = '{1'b1, 8'd255, 1'b1, 8'b1000_0000};
        vecs[7]  = '{1'b1, 8'd5,   1'b1, 8'b0000_0111};
        vecs[8]  = '{1'b0, 8'd0,   1'b0, 8'b0000_0111};
        vecs[9]  = '{1'b0, 8'd0,   1'b0, 8'b0000_0111};
        vecs[10] = '{1'b1, 8'd6,   1'b1, 8'b0000_0101};
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].en, vecs[i].en ? vecs[i].data : 8'($urandom));
            check($sformatf("vec%0d_vld", i), {31'd0, vld}, {31'd0, vecs[i].exp_vld});
            check($sformatf("vec%0d_gray", i), {24'd0, gray}, {24'd0, vecs[i].exp_gray});
        end

        // Mid-stream reset at data=100, held across three edges.
        for (int i = 90; i <= 100; i++) begin
            cyc(1'b1, 8'(i));
            chk_model("mid_pre");
        end
        rst_n = 1'b0;
        #1;
        check("mid_async_vld", {31'd0, vld}, 32'd0);
        check("mid_async_gray", {24'd0, gray}, 32'd0);
        for (int i = 101; i < 104; i++) begin
            cyc(1'b1, 8'(i));
            chk_model("mid_rst");
        end
        rst_n = 1'b1;
        cyc(1'b1, 8'd200);
        chk_model("mid_resume");
        check("mid_resume_200", {24'd0, gray}, 32'hAC);
        cyc(1'b0, 8'd0);

        // Narrow instance, 4-bit sweep.
        exp_s = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        for (int i = 0; i < 16; i++) begin
            en_s   = 1'b1;
            data_s = 4'(i);
            cyc(1'b0, 8'd0);
            check($sformatf("w4_vld%0d", i), {31'd0, vld_s}, 32'd1);
            check($sformatf("w4_gray%0d", i), {28'd0, gray_s}, {28'd0, exp_s[i]});
        end
        en_s = 1'b0;
        cyc(1'b0, 8'd0);
        check("w4_idle_vld", {31'd0, vld_s}, 32'd0);
        check("w4_hold_gray", {28'd0, gray_s}, 32'd8);

        // Randomized run against the model.
        for (int i = 0; i < 10000; i++) begin
            e = 1'($urandom_range(0, 3) != 0);
            cyc(e, 8'($urandom));
            chk_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
